// File: rtl/pc_sequencer_if.sv
// Bus between the EXEC stage and pc_sequencer. When PC_SEQUENCER_EXCEPTION_EN is
// defined it also carries the exception request and the exception status.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  // Handshake: advance is the valid and ~stall is the ready. A step happens on a
  // clk edge only when both hold and the sequencer is not halted. Every step
  // takes the jump fields that are present on that same edge. The step has no
  // backpressure beyond stall.
  logic              advance;
  logic              stall;
  logic              jump_valid;
  logic [1:0]        jump_mode;
  logic [25:0]       jump_imm;
  logic [ADDR_W-1:0] jump_reg;
  logic [ADDR_W-1:0] pc;
  logic              in_delay_slot;
  logic              finish;
  logic              dslot_err;
  logic [CNT_W-1:0]  retired;
  logic [1:0]        state;
`ifdef PC_SEQUENCER_EXCEPTION_EN
  logic              exc_req;
  logic              exc_taken;
  logic [ADDR_W-1:0] epc;
`endif

  modport master (
    output advance, stall, jump_valid, jump_mode, jump_imm, jump_reg,
`ifdef PC_SEQUENCER_EXCEPTION_EN
    output exc_req,
    input  exc_taken, epc,
`endif
    input  pc, in_delay_slot, finish, dslot_err, retired, state
  );

  modport slave (
    input  advance, stall, jump_valid, jump_mode, jump_imm, jump_reg,
`ifdef PC_SEQUENCER_EXCEPTION_EN
    input  exc_req,
    output exc_taken, epc,
`endif
    output pc, in_delay_slot, finish, dslot_err, retired, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS controlpath. It handles an optional delay
// slot, halts at the exit address and counts retired instructions. Define
// PC_SEQUENCER_EXCEPTION_EN to add the exception redirect (exc_req/exc_taken/epc).
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] EXIT_ADDR    = 32'h0,
  parameter int          DELAY_SLOT   = 1,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] EXIT_PC = ADDR_W'(EXIT_ADDR);
  localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(3);

  typedef enum logic [1:0] {RUN = 2'd0, SLOT = 2'd1, HALT = 2'd2} state_t;

  state_t            state, nxt_state;
  logic [ADDR_W-1:0] pc_q, pend_q, nxt_pc, nxt_pend;
  logic [ADDR_W-1:0] p4, page_t, rel_t, target;
  logic              ds_q, err_q, fin_q, nxt_ds, nxt_err;
  logic [CNT_W-1:0]  ret_q;
  logic              step, jump_taken;
`ifdef PC_SEQUENCER_EXCEPTION_EN
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VECTOR);
  logic              exc, exc_taken_q;
  logic [ADDR_W-1:0] epc_q, nxt_epc;
`endif

  always_comb begin
    p4           = pc_q + ADDR_W'(4);
    page_t       = p4;
    page_t[27:0] = {bus.jump_imm, 2'b00};
    rel_t        = p4 + {{(ADDR_W-18){bus.jump_imm[15]}}, bus.jump_imm[15:0], 2'b00};
    case (bus.jump_mode)
      2'b01:   target = bus.jump_reg & ALIGN_M;
      2'b10:   target = page_t;
      2'b11:   target = rel_t;
      default: target = p4;
    endcase
  end

  always_comb begin
    step       = bus.advance & ~bus.stall & (state != HALT);
    jump_taken = bus.jump_valid & (bus.jump_mode != 2'b00);
    nxt_pc     = pc_q;
    nxt_state  = state;
    nxt_pend   = pend_q;
    nxt_ds     = ds_q;
    nxt_err    = err_q;
`ifdef PC_SEQUENCER_EXCEPTION_EN
    // A misaligned register target traps instead of being silently aligned.
    exc     = bus.exc_req |
              ((state == RUN) & jump_taken & (bus.jump_mode == 2'b01) &
               (bus.jump_reg[1:0] != 2'b00));
    nxt_epc = (state == SLOT) ? pc_q - ADDR_W'(4) : pc_q;
`endif
    if (step) begin
`ifdef PC_SEQUENCER_EXCEPTION_EN
      if (exc) begin
        nxt_pc    = EXC_PC;
        nxt_state = RUN;
        nxt_pend  = '0;
        nxt_ds    = 1'b0;
      end else
`endif
      if (state == SLOT) begin
        nxt_pc    = pend_q;
        nxt_state = RUN;
        nxt_ds    = 1'b0;
        if (jump_taken) nxt_err = 1'b1;
      end else if (jump_taken && (DELAY_SLOT != 0)) begin
        nxt_pend  = target;
        nxt_pc    = p4;
        nxt_state = SLOT;
        nxt_ds    = 1'b1;
      end else if (jump_taken) begin
        nxt_pc = target;
      end else begin
        nxt_pc = p4;
      end
      // Reaching the exit address halts from any path and drops a pending target.
      if (nxt_pc == EXIT_PC) begin
        nxt_state = HALT;
        nxt_ds    = 1'b0;
        nxt_pend  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RST_PC;
      state  <= (RST_PC == EXIT_PC) ? HALT : RUN;
      fin_q  <= (RST_PC == EXIT_PC);
      pend_q <= '0;
      ds_q   <= 1'b0;
      err_q  <= 1'b0;
      ret_q  <= '0;
`ifdef PC_SEQUENCER_EXCEPTION_EN
      epc_q       <= '0;
      exc_taken_q <= 1'b0;
`endif
    end else begin
      if (step) begin
        pc_q   <= nxt_pc;
        state  <= nxt_state;
        fin_q  <= (nxt_state == HALT);
        pend_q <= nxt_pend;
        ds_q   <= nxt_ds;
        err_q  <= nxt_err;
        ret_q  <= ret_q + CNT_W'(1);
      end
`ifdef PC_SEQUENCER_EXCEPTION_EN
      exc_taken_q <= step & exc;
      if (step && exc) epc_q <= nxt_epc;
`endif
    end
  end

  assign bus.pc            = pc_q;
  assign bus.in_delay_slot = ds_q;
  assign bus.finish        = fin_q;
  assign bus.dslot_err     = err_q;
  assign bus.retired       = ret_q;
  assign bus.state         = state;
`ifdef PC_SEQUENCER_EXCEPTION_EN
  assign bus.exc_taken     = exc_taken_q;
  assign bus.epc           = epc_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. Instance a uses delay-slot semantics and is
// compared against a reference model. Instance b uses immediate redirect.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(32), .CNT_W(32)) ifa ();
  pc_sequencer_if #(.ADDR_W(32), .CNT_W(32)) ifb ();

  pc_sequencer #(.DELAY_SLOT(1)) dut_a (.clk(clk), .reset(reset_a), .bus(ifa));
  pc_sequencer #(.DELAY_SLOT(0)) dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

  // reference model: state 0 run, 1 slot, 2 halt; exit address 0
  logic [31:0] m_pc, m_pend, m_ret;
  logic [1:0]  m_st;
  logic        m_ds, m_fin, m_err;
  logic [68:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'hBFC00000; m_pend = '0; m_ret = '0; m_st = 2'd0;
    m_ds = 1'b0; m_fin = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic adv, stl, jv, input logic [1:0] jm,
                            input logic [25:0] imm, input logic [31:0] jreg);
    logic [31:0] p4, tgt, npc;
    if (!(adv && !stl && m_st != 2'd2)) return;
    p4 = m_pc + 32'd4;
    case (jm)
      2'b01:   tgt = {jreg[31:2], 2'b00};
      2'b10:   tgt = {p4[31:28], imm, 2'b00};
      default: tgt = p4 + {{14{imm[15]}}, imm[15:0], 2'b00};
    endcase
    if (m_st == 2'd1) begin
      npc = m_pend; m_st = 2'd0; m_ds = 1'b0;
      if (jv && jm != 2'b00) m_err = 1'b1;
    end else if (jv && jm != 2'b00) begin
      m_pend = tgt; npc = p4; m_st = 2'd1; m_ds = 1'b1;
    end else begin
      npc = p4;
    end
    m_ret = m_ret + 32'd1;
    m_pc  = npc;
    if (npc == 32'd0) begin
      m_st = 2'd2; m_fin = 1'b1; m_ds = 1'b0;
    end
  endtask

  task automatic compare_a(input string tag);
    logic [68:0] e;
    e = exp_q.pop_front();
    check({tag, "_pc"},  64'(ifa.pc),            64'(e[68:37]));
    check({tag, "_ret"}, 64'(ifa.retired),       64'(e[36:5]));
    check({tag, "_st"},  64'(ifa.state),         64'(e[4:3]));
    check({tag, "_ds"},  64'(ifa.in_delay_slot), 64'(e[2]));
    check({tag, "_fin"}, 64'(ifa.finish),        64'(e[1]));
    check({tag, "_err"}, 64'(ifa.dslot_err),     64'(e[0]));
  endtask

  task automatic drive_a(input logic adv, stl, jv, input logic [1:0] jm,
                         input logic [25:0] imm, input logic [31:0] jreg);
    ifa.advance = adv; ifa.stall = stl; ifa.jump_valid = jv;
    ifa.jump_mode = jm; ifa.jump_imm = imm; ifa.jump_reg = jreg;
    model_step(adv, stl, jv, jm, imm, jreg);
    exp_q.push_back({m_pc, m_ret, m_st, m_ds, m_fin, m_err});
    @(posedge clk); #1;
    compare_a("step");
  endtask

  task automatic reset_dut_a();
    reset_a = 1'b0;
    ifa.advance = 1'b1; ifa.stall = 1'b0; ifa.jump_valid = 1'b1;
    ifa.jump_mode = 2'b11; ifa.jump_imm = 26'h0000010; ifa.jump_reg = '0;
    model_reset();
    exp_q.push_back({m_pc, m_ret, m_st, m_ds, m_fin, m_err});
    @(posedge clk); #1;
    compare_a("rst");
    reset_a = 1'b1;
    ifa.advance = 1'b0; ifa.jump_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    ifb.advance = 1'b0; ifb.stall = 1'b0; ifb.jump_valid = 1'b0;
    ifb.jump_mode = 2'b00; ifb.jump_imm = '0; ifb.jump_reg = '0;
    @(posedge clk); #1;
    reset_dut_a();

    // three sequential steps
    for (int i = 0; i < 3; i++) drive_a(1, 0, 0, 2'b00, 26'h0, 32'h0);
    check("seq3_pc", 64'(ifa.pc), 64'h00000000BFC0000C);
    check("seq3_ret", 64'(ifa.retired), 64'd3);
    drive_a(1, 0, 0, 2'b00, 26'h0, 32'h0);

    // relative branch back by two words, with the delay slot in between
    drive_a(1, 0, 1, 2'b11, 26'h000FFFE, 32'h0);
    check("rel_slot_pc", 64'(ifa.pc), 64'h00000000BFC00014);
    check("rel_slot_ds", 64'(ifa.in_delay_slot), 64'd1);
    drive_a(1, 0, 0, 2'b00, 26'h0, 32'h0);
    check("rel_tgt_pc", 64'(ifa.pc), 64'h00000000BFC0000C);

    // a jump requested inside the slot is ignored but flagged
    drive_a(1, 0, 1, 2'b11, 26'h0000004, 32'h0);
    drive_a(1, 0, 1, 2'b11, 26'h0000100, 32'h0);
    check("dslot_pc", 64'(ifa.pc), 64'h00000000BFC00020);
    check("dslot_err", 64'(ifa.dslot_err), 64'd1);

    // enter a slot, stall through five advance pulses, then reset mid-slot
    drive_a(1, 0, 1, 2'b10, 26'h3F00010, 32'h0);
    for (int i = 0; i < 5; i++) drive_a(1, 1, 0, 2'b00, 26'h0, 32'h0);
    check("stall_pc", 64'(ifa.pc), 64'h00000000BFC00024);
    check("stall_ret", 64'(ifa.retired), 64'd9);
    reset_dut_a();
    check("rst_slot_pc", 64'(ifa.pc), 64'h00000000BFC00000);

    // JR to the exit address halts; further advances change nothing
    for (int i = 0; i < 8; i++) drive_a(1, 0, 0, 2'b00, 26'h0, 32'h0);
    drive_a(1, 0, 1, 2'b01, 26'h0, 32'h0);
    drive_a(1, 0, 0, 2'b00, 26'h0, 32'h0);
    check("halt_fin", 64'(ifa.finish), 64'd1);
    for (int i = 0; i < 3; i++) drive_a(1, 0, 1, 2'b11, 26'h0000040, 32'h0);
    check("halt_pc", 64'(ifa.pc), 64'd0);
    check("halt_ret", 64'(ifa.retired), 64'd10);

    // misaligned register target is aligned down
    reset_dut_a();
    check("rst_err_clr", 64'(ifa.dslot_err), 64'd0);
    drive_a(1, 0, 1, 2'b01, 26'h0, 32'hBFC00103);
    drive_a(1, 0, 0, 2'b00, 26'h0, 32'h0);
    check("jr_align_pc", 64'(ifa.pc), 64'h00000000BFC00100);

    // random traffic against the model
    for (int r = 0; r < 3; r++) begin
      reset_dut_a();
      for (int i = 0; i < 100; i++) begin
        logic [31:0] jreg;
        jreg = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
        drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                26'($urandom), jreg);
      end
    end

    // immediate redirect instance
    @(posedge clk); #1;
    check("b_rst_pc", 64'(ifb.pc), 64'h00000000BFC00000);
    reset_b = 1'b1;
    ifb.advance = 1'b1; ifb.jump_valid = 1'b1;
    ifb.jump_mode = 2'b10; ifb.jump_imm = 26'h0000040;
    @(posedge clk); #1;
    check("b_page_pc", 64'(ifb.pc), 64'h00000000B0000100);
    check("b_page_ds", 64'(ifb.in_delay_slot), 64'd0);
    ifb.jump_mode = 2'b11; ifb.jump_imm = 26'h000FFFC;
    @(posedge clk); #1;
    check("b_rel_pc", 64'(ifb.pc), 64'h00000000B00000F4);
    check("b_ret", 64'(ifb.retired), 64'd2);
    ifb.advance = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
